// File: rtl/bist_pkg.sv
// Shared types and defaults for the RAM BIST sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bist_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    // Highest address for the default geometry; the generator is reset here
    // rather than being allowed to wrap.
    localparam logic [ADDR_W_DEF-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WRITE,
        S_READ,
        S_COMPARE,
        S_NEXT_PAT,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/bist_controller.sv
// Walking-one RAM BIST sequencer driving an external pattern/count generator and RAM.
// Latency: clean run is 1 + DATA_W*(3*2^ADDR_W + 1) cycles from the start-sampling edge to done.
// Backpressure: none; start is only honoured in IDLE/DONE/FAIL and ignored while busy.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   start                        begin (or restart) a test
//   pat, count                   generator state; pat[DATA_W] marks patterns exhausted
//   ram_rdata                    RAM read data, one cycle after ram_addr
//   count_rst, pat_rst,
//   nxt_count_trig, nxt_pat_trig generator controls (Moore, except in COMPARE/WRITE at LAST)
//   ram_we, ram_addr, ram_wdata  RAM write port / address
//   busy, done, pass, error      status
//   fail_addr, fail_pat          first failing address and pattern
module bist_controller
    import bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W:0]   pat,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              count_rst,
    output logic              pat_rst,
    output logic              nxt_count_trig,
    output logic              nxt_pat_trig,
    output logic              error,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_pat
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_pat_q, fail_pat_d;
    logic              is_last;

    assign is_last = (count == LAST);

    always_comb begin
        state_d        = state_q;
        error_d        = error_q;
        fail_addr_d    = fail_addr_q;
        fail_pat_d     = fail_pat_q;
        count_rst      = 1'b0;
        pat_rst        = 1'b0;
        nxt_count_trig = 1'b0;
        nxt_pat_trig   = 1'b0;
        ram_we         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                count_rst = 1'b1;
                pat_rst   = 1'b1;
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                count_rst   = 1'b1;
                pat_rst     = 1'b1;
                error_d     = 1'b0;
                fail_addr_d = '0;
                fail_pat_d  = '0;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                ram_we = 1'b1;
                // Reset at LAST instead of incrementing so the count never wraps.
                if (is_last) begin
                    count_rst = 1'b1;
                    state_d   = S_READ;
                end else begin
                    nxt_count_trig = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (ram_rdata != pat[DATA_W-1:0]) begin
                    // No count trigger here: the generator freezes on the failing address.
                    error_d     = 1'b1;
                    fail_addr_d = count;
                    fail_pat_d  = pat[DATA_W-1:0];
                    state_d     = S_FAIL;
                end else if (is_last) begin
                    count_rst    = 1'b1;
                    nxt_pat_trig = 1'b1;
                    state_d      = S_NEXT_PAT;
                end else begin
                    nxt_count_trig = 1'b1;
                    state_d        = S_READ;
                end
            end
            S_NEXT_PAT: begin
                // The shifted pattern is only visible now, one cycle after the trigger.
                state_d = pat[DATA_W] ? S_DONE : S_WRITE;
            end
            S_DONE, S_FAIL: begin
                // Generator is left untouched so its final state stays observable.
                if (start) state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            error_q     <= 1'b0;
            fail_addr_q <= '0;
            fail_pat_q  <= '0;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            fail_addr_q <= fail_addr_d;
            fail_pat_q  <= fail_pat_d;
        end
    end

    assign ram_addr  = count;
    assign ram_wdata = pat[DATA_W-1:0];
    assign error     = error_q;
    assign fail_addr = fail_addr_q;
    assign fail_pat  = fail_pat_q;
    assign busy      = (state_q == S_INIT) || (state_q == S_WRITE) || (state_q == S_READ)
                     || (state_q == S_COMPARE) || (state_q == S_NEXT_PAT);
    assign done      = (state_q == S_DONE) || (state_q == S_FAIL);
    assign pass      = done & ~error_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller with a behavioural generator and faultable RAM.
// Latency: runs at ADDR_W=8 so a clean run is 1 + 8*(3*256+1) = 6153 cycles.
// Backpressure: n/a.
module tb_bist_controller;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int EXP_CYC = 1 + DW * (3 * (1 << AW) + 1);
    localparam int BUDGET  = 8000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW:0]   pat   = '0;
    logic [AW-1:0] count = '0;
    logic [DW-1:0] ram_rdata = '0;
    logic          count_rst, pat_rst, nxt_count_trig, nxt_pat_trig;
    logic          error, ram_we, busy, done, pass;
    logic [AW-1:0] ram_addr, fail_addr;
    logic [DW-1:0] ram_wdata, fail_pat;

    // 0 = fault-free, 1 = stuck-at-0 bit on read, 2 = writes to LAST alias to 0
    int            fault_kind = 0;
    logic [AW-1:0] fault_addr = '0;
    int            fault_bit  = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] rd_val;

    int total   = 0;
    int bad     = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    bist_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .pat(pat), .count(count),
        .ram_rdata(ram_rdata), .count_rst(count_rst), .pat_rst(pat_rst),
        .nxt_count_trig(nxt_count_trig), .nxt_pat_trig(nxt_pat_trig),
        .error(error), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_pat(fail_pat)
    );

    // Pattern/count generator: resets win over increments, increments freeze on error.
    always @(posedge clk) begin
        if (count_rst) count <= '0;
        else if (nxt_count_trig && !error) count <= count + 1'b1;
        if (pat_rst) pat <= 1;
        else if (nxt_pat_trig && !error) pat <= pat << 1;
    end

    // Synchronous RAM with optional fault.
    always @(posedge clk) begin
        wr_addr = ram_addr;
        if (fault_kind == 2 && ram_addr == {AW{1'b1}}) wr_addr = '0;
        if (ram_we) mem[wr_addr] <= ram_wdata;
        rd_val = mem[ram_addr];
        if (fault_kind == 1 && ram_addr == fault_addr) rd_val[fault_bit] = 1'b0;
        ram_rdata <= rd_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses start from a negedge, then follows the run until done or the budget expires.
    // A second start pulse is driven at cycle pulse_n (when > 0).
    task automatic run_one(input int pulse_n, output int cyc);
        int n;
        n = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        while (!done && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (count_rst && nxt_count_trig) overlap++;
            if (n == 1) begin
                chk("init_clears_error", error, 0);
                chk("init_clears_fail_addr", fail_addr, 0);
                chk("init_clears_fail_pat", fail_pat, 0);
            end
            if (pulse_n > 0 && n == pulse_n + 1) chk("mid_start_ignored", pat_rst, 0);
            start = (n == pulse_n);
        end
        start = 1'b0;
        chk("run_reaches_done", done, 1);
        cyc = n;
    endtask

    typedef struct {
        int            kind;
        logic [AW-1:0] faddr;
        int            fbit;
        bit            exp_pass;
        logic [AW-1:0] exp_faddr;
        logic [DW-1:0] exp_fpat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc;
        int k;

        vecs[0] = '{0, 8'h00, 0, 1'b1, 8'h00, 8'h00};  // clean from IDLE
        vecs[1] = '{1, 8'h55, 3, 1'b0, 8'h55, 8'h08};  // stuck-at-0 bit 3
        vecs[2] = '{0, 8'h00, 0, 1'b1, 8'h00, 8'h00};  // restart after FAIL, fault removed
        vecs[3] = '{2, 8'h00, 0, 1'b0, 8'hFF, 8'h01};  // LAST aliases onto 0
        vecs[4] = '{1, 8'h00, 0, 1'b0, 8'h00, 8'h01};  // first address, first pattern
        vecs[5] = '{1, 8'hFF, 7, 1'b0, 8'hFF, 8'h80};  // last address, last pattern
        vecs[6] = '{0, 8'h00, 0, 1'b1, 8'h00, 8'h00};  // clean after FAIL

        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_error", error, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_pat", fail_pat, 0);
        chk("rst_count_rst", count_rst, 1);
        chk("rst_pat_rst", pat_rst, 1);
        chk("rst_ram_we", ram_we, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fault_kind = vecs[i].kind;
            fault_addr = vecs[i].faddr;
            fault_bit  = vecs[i].fbit;
            run_one(-1, cyc);
            chk("end_pass", pass, 32'(vecs[i].exp_pass));
            chk("end_error", error, 32'(!vecs[i].exp_pass));
            chk("end_busy", busy, 0);
            if (vecs[i].exp_pass) begin
                chk("clean_cycles", cyc, EXP_CYC);
                chk("clean_final_pat", pat, 9'h100);
            end else begin
                chk("fail_addr", fail_addr, vecs[i].exp_faddr);
                chk("fail_pat", fail_pat, vecs[i].exp_fpat);
                chk("frozen_count", count, vecs[i].exp_faddr);
                chk("frozen_pat", pat[DW-1:0], vecs[i].exp_fpat);
            end
            repeat (3) @(negedge clk);
            chk("hold_done", done, 1);
            chk("hold_pass", pass, 32'(vecs[i].exp_pass));
            if (!vecs[i].exp_pass) chk("hold_count", count, vecs[i].exp_faddr);
        end
        fault_kind = 0;

        // Start pulsed while in READ of the first pattern must be ignored.
        run_one(1 + (1 << AW), cyc);
        chk("mid_start_cycles", cyc, EXP_CYC);
        chk("mid_start_pass", pass, 1);

        // Reset during WRITE of pattern 0x10 aborts, then a fresh run completes.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(ram_we && pat == 9'h010) && k < BUDGET) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("reach_write_pat10", 32'(ram_we && pat == 9'h010), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count_rst", count_rst, 1);
        chk("abort_pat_rst", pat_rst, 1);
        chk("abort_ram_we", ram_we, 0);
        run_one(-1, cyc);
        chk("after_abort_cycles", cyc, EXP_CYC);
        chk("after_abort_pass", pass, 1);

        chk("no_rst_trig_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequencing FSM for the RAM BIST. It drives the walking-one pattern/address generator (pat 9 bits, count 11 bits) and the RAM under test.
- For each pattern value 1,2,4,…,128 it writes the pattern to every address, then reads back every address and compares.
- It stops on the first mismatch, latching the failing address and pattern, or reports pass once pat[8] is reached.
- It sits between the top-level start/status interface and the generator + RAM instances.

Parameters:
- ADDR_W, 11, address/count width; last address LAST = 2^ADDR_W-1.
- DATA_W, 8, RAM data width; equals the number of walking-one patterns.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE, DONE, FAIL.
- pat  in  DATA_W+1  pattern from generator; pat[DATA_W] = all patterns exhausted.
- count  in  ADDR_W  current address from generator.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr.
- count_rst  out  1  generator count reset (priority over count increment).
- pat_rst  out  1  generator pattern reset (pat←1).
- nxt_count_trig  out  1  advance count.
- nxt_pat_trig  out  1  advance pattern (pat←pat*2).
- error  out  1  sticky mismatch flag; also freezes the generator.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  equals count.
- ram_wdata  out  DATA_W  equals pat[DATA_W-1:0].
- busy  out  1  high in INIT/WRITE/READ/COMPARE/NEXT_PAT.
- done  out  1  high in DONE or FAIL.
- pass  out  1  high in DONE only.
- fail_addr  out  ADDR_W  count captured at mismatch.
- fail_pat  out  DATA_W  pattern captured at mismatch.

Behaviour:
- Reset: state IDLE; error, fail_addr, fail_pat ←0. Mid-test rst aborts immediately to IDLE.
- Control outputs are decoded from state (Moore), except where noted. Default is 0.
- IDLE: count_rst=pat_rst=1. start → INIT.
- INIT (1 cycle): count_rst=pat_rst=1; error←0; fail_addr/fail_pat←0. → WRITE.
- WRITE (1 cycle/address): ram_we=1.
  - count≠LAST: nxt_count_trig=1, stay.
  - count=LAST: count_rst=1, → READ.
- READ: present address, ram_we=0. → COMPARE.
- COMPARE, ram_rdata≠pat[DATA_W-1:0]:
  - error←1, fail_addr←count, fail_pat←pat[DATA_W-1:0].
  - nxt_count_trig=0 so the generator freezes.
  - → FAIL.
- COMPARE, match:
  - count≠LAST: nxt_count_trig=1, → READ.
  - count=LAST: count_rst=1, nxt_pat_trig=1, → NEXT_PAT.
- NEXT_PAT (1 cycle, lets the updated pat settle): pat[DATA_W]=1 → DONE, else → WRITE.
- DONE / FAIL:
  - Hold all status; generator outputs are not reset, so they stay visible for debug.
  - start → INIT (restart).
- start is ignored while busy.
- Latency: a clean run takes exactly 1 + DATA_W·(3·2^ADDR_W + 1) cycles from the edge sampling start (IDLE/DONE/FAIL) to the first done=1 cycle. Defaults: 49161.
- Count wrap: count_rst is always asserted at LAST, so the generator never wraps through 0 by increment.
- Simultaneous count_rst and nxt_count_trig never occur.
- error is cleared only by INIT or rst.
- pass = done & ~error.

Decomposition:
- Package bist_pkg holds:
  - state enum (IDLE, INIT, WRITE, READ, COMPARE, NEXT_PAT, DONE, FAIL);
  - ADDR_W/DATA_W defaults;
  - LAST_ADDR constant.
- No sub-module. The pattern/count generator and RAM are instanced beside this block at top level.

Test Plan:
- Clean run (fault-free RAM model + generator): pulse start in IDLE → busy immediately, done=pass=1 exactly 49161 cycles later, error=0; the final observed pat is 9'h100.
- Stuck-at-0 bit 3 at address 0x155: pat 1,2,4 pass; first failure on pattern 8'h08 → FAIL, fail_addr=0x155, fail_pat=8'h08, error=1, pass=0; count stays frozen at 0x155.
- Address alias (writes to 0x7FF land at 0x000): first read of 0x000 in pattern 1 returns 0x01 and matches; read of 0x7FF returns stale data → fail_addr=0x7FF, fail_pat=8'h01.
- rst asserted during WRITE of pattern 8'h10 → next cycle IDLE, busy=0, done=0, count_rst=pat_rst=1; a new start gives a full clean run of 49161 cycles.
- Restart after FAIL: start in FAIL → INIT clears error/fail_addr/fail_pat to 0; with the fault removed, the run ends in DONE with pass=1.
- start pulsed mid-run (in READ) → ignored: no INIT, and done timing is unchanged.
